mensaje_tx_scheduler: RTL and testbench

Shares one byte-wide UART transmit path between two telemetry requesters: channel 0 (RPM, signed) and channel 1 (second sensor).
- Round-robin arbitration between the two channels.
- Latches the winner's BCD value and sign, composes the 6-byte ASCII frame (sign char, 4 digit chars, termination char) and streams it byte by byte over a valid/ready handshake.
- Enforces a programmable idle gap between frames.

---
 rtl/mensaje_tx_scheduler_pkg.sv | 27 ++
 rtl/mensaje_tx_scheduler_if.sv | 20 ++
 rtl/mensaje_tx_scheduler_arb.sv | 31 +++
 rtl/mensaje_tx_scheduler.sv | 137 +++++++++++++
 tb/tb_mensaje_tx_scheduler.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mensaje_tx_scheduler_pkg.sv
// Shared constants, FSM state type and ASCII helpers for the telemetry TX scheduler.
package mensaje_pkg;

   localparam logic [7:0] SIGNO_POSITIVO = 8'd33;  // '!'
   localparam logic [7:0] SIGNO_NEGATIVO = 8'd35;  // '#'
   localparam logic [7:0] ASCII_ZERO     = 8'd48;  // '0'
   localparam logic [7:0] ASCII_ERR      = 8'd63;  // '?'
   localparam int         FRAME_BYTES    = 6;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      GAP
   } state_t;

   // One BCD nibble to its ASCII digit; anything above 9 becomes '?'.
   function automatic logic [7:0] digit_char(input logic [3:0] nib);
      return (nib > 4'd9) ? ASCII_ERR : (ASCII_ZERO + {4'h0, nib});
   endfunction

   // True when any of the four nibbles is not a decimal digit.
   function automatic logic bcd_invalid(input logic [15:0] bcd);
      return (bcd[3:0] > 4'd9) || (bcd[7:4] > 4'd9) ||
             (bcd[11:8] > 4'd9) || (bcd[15:12] > 4'd9);
   endfunction

endpackage

// File: rtl/mensaje_tx_scheduler_if.sv
// Byte stream towards the UART transmitter: valid/ready handshake.
interface mensaje_tx_scheduler_if;

   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready
   );

endinterface

// File: rtl/mensaje_tx_scheduler_arb.sv
// Two-way round-robin grant. Purely combinational; the caller owns last_grant.
module rr_arbiter_2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant_valid,
   output logic       grant_id
);

   // Single requester wins outright; on a tie the channel that did not win last time goes.
   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
      grant_valid = 1'b0;
      grant_id    = 1'b0;
      case (req)
         2'b01: begin
            grant_valid = 1'b1;
            grant_id    = 1'b0;
         end
         2'b10: begin
            grant_valid = 1'b1;
            grant_id    = 1'b1;
         end
         2'b11: begin
            grant_valid = 1'b1;
            grant_id    = ~last_grant;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mensaje_tx_scheduler.sv
// Shares one UART byte path between two BCD telemetry channels: arbitrates,
// latches the winner, sends a 6-byte ASCII frame and then holds an idle gap.
module mensaje_tx_scheduler
   import mensaje_pkg::*;
#(
   parameter logic [7:0] TERM_CH0   = 8'd82,  // 'R'
   parameter logic [7:0] TERM_CH1   = 8'd84,  // 'T'
   parameter int         GAP_CYCLES = 16,
   parameter int         GAP_W      = 8
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         req0,
   input  logic [15:0]                  bcd0,
   input  logic                         signo0,
   output logic                         ack0,
   input  logic                         req1,
   input  logic [15:0]                  bcd1,
   input  logic                         signo1,
   output logic                         ack1,
   mensaje_tx_scheduler_if.master       tx,
   output logic                         busy,
   output logic                         digit_err
);

   localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [2:0]       LAST_BYTE = 3'(FRAME_BYTES - 1);

   state_t      state;
   logic [2:0]  byte_idx;
   logic [GAP_W-1:0] gap_cnt;
   logic        last_grant;
   logic [15:0] bcd_q;
   logic        chan_q;

   logic        grant_valid;
   logic        grant_id;
   logic [15:0] sel_bcd;
   logic        sel_signo;
   logic [7:0]  next_byte;

   rr_arbiter_2 u_arb (
      .req         ({req1, req0}),
      .last_grant  (last_grant),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   assign sel_bcd   = grant_id ? bcd1 : bcd0;
   assign sel_signo = grant_id ? signo1 : signo0;

   // Byte that follows the one currently on tx_data, built from the latched frame.
   always_comb begin
      next_byte = 8'd0;
      case (byte_idx)
         3'd0:    next_byte = digit_char(bcd_q[3:0]);
         3'd1:    next_byte = digit_char(bcd_q[7:4]);
         3'd2:    next_byte = digit_char(bcd_q[11:8]);
         3'd3:    next_byte = digit_char(bcd_q[15:12]);
         3'd4:    next_byte = chan_q ? TERM_CH1 : TERM_CH0;
         default: next_byte = 8'd0;
      endcase
   end

   // Frame FSM: grant and latch in IDLE, stream bytes in SEND, count the gap in GAP.
   always_ff @(posedge clock) begin
      // NOTE: non-blocking throughout so every register sees the pre-edge values.
      if (reset) begin
         state       <= IDLE;
         byte_idx    <= 3'd0;
         gap_cnt     <= '0;
         last_grant  <= 1'b1;
         bcd_q       <= 16'd0;
         chan_q      <= 1'b0;
         ack0        <= 1'b0;
         ack1        <= 1'b0;
         tx.tx_valid <= 1'b0;
         tx.tx_data  <= 8'd0;
         busy        <= 1'b0;
         digit_err   <= 1'b0;
      end else begin
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         digit_err <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_valid) begin
                  state       <= SEND;
                  busy        <= 1'b1;
                  byte_idx    <= 3'd0;
                  last_grant  <= grant_id;
                  chan_q      <= grant_id;
                  bcd_q       <= sel_bcd;
                  ack0        <= ~grant_id;
                  ack1        <= grant_id;
                  digit_err   <= bcd_invalid(sel_bcd);
                  tx.tx_valid <= 1'b1;
                  tx.tx_data  <= sel_signo ? SIGNO_POSITIVO : SIGNO_NEGATIVO;
               end
            end
            SEND: begin
               if (tx.tx_ready) begin
                  if (byte_idx == LAST_BYTE) begin
                     tx.tx_valid <= 1'b0;
                     tx.tx_data  <= 8'd0;
                     byte_idx    <= 3'd0;
                     if (GAP_CYCLES > 0) begin
                        state   <= GAP;
                        gap_cnt <= '0;
                     end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                     end
                  end else begin
                     byte_idx   <= byte_idx + 3'd1;
                     tx.tx_data <= next_byte;
                  end
               end
            end
            GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  gap_cnt <= '0;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mensaje_tx_scheduler.sv
// Directed bench for mensaje_tx_scheduler: reset, single frame, round robin,
// backpressure, invalid digits, input freeze and mid-frame reset.
module tb_mensaje_tx_scheduler;

   localparam int GAP = 16;

   logic        clock = 1'b0;
   logic        reset;
   logic        req0, req1, signo0, signo1;
   logic [15:0] bcd0, bcd1;
   logic        ack0, ack1, busy, digit_err;

   mensaje_tx_scheduler_if ifc ();

   mensaje_tx_scheduler #(
      .TERM_CH0   (8'd82),
      .TERM_CH1   (8'd84),
      .GAP_CYCLES (GAP),
      .GAP_W      (8)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .req0      (req0),
      .bcd0      (bcd0),
      .signo0    (signo0),
      .ack0      (ack0),
      .req1      (req1),
      .bcd1      (bcd1),
      .signo1    (signo1),
      .ack1      (ack1),
      .tx        (ifc),
      .busy      (busy),
      .digit_err (digit_err)
   );

   always #5 clock = ~clock;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] got [6];
   logic [7:0] exp_b [6];
   int         got_n, hold_viol, n_ack0, n_ack1, n_derr, n_both;

   // Records accepted bytes from the current negedge on; ready follows a 4-cycle pattern.
   task automatic collect(input logic [3:0] pat, input int budget);
      logic       prev_stall;
      logic [7:0] prev_data;
      got_n = 0; hold_viol = 0; n_ack0 = 0; n_ack1 = 0; n_derr = 0; n_both = 0;
      prev_stall = 1'b0;
      prev_data  = 8'd0;
      for (int i = 0; i < 6; i++) got[i] = 8'd0;
      for (int k = 0; k < budget && got_n < 6; k++) begin
         ifc.tx_ready = pat[k % 4];
         if (prev_stall && (ifc.tx_valid !== 1'b1 || ifc.tx_data !== prev_data)) hold_viol++;
         if (ack0 === 1'b1) n_ack0++;
         if (ack1 === 1'b1) n_ack1++;
         if (ack0 === 1'b1 && ack1 === 1'b1) n_both++;
         if (digit_err === 1'b1) n_derr++;
         if (ifc.tx_valid === 1'b1 && ifc.tx_ready === 1'b1) begin
            got[got_n] = ifc.tx_data;
            got_n++;
         end
         prev_stall = (ifc.tx_valid === 1'b1) && (ifc.tx_ready !== 1'b1);
         prev_data  = ifc.tx_data;
         @(negedge clock);
      end
      ifc.tx_ready = 1'b1;
   endtask

   task automatic wait_valid(input int budget, output int waited);
      waited = -1;
      for (int k = 0; k < budget; k++) begin
         if (ifc.tx_valid === 1'b1) begin
            waited = k;
            return;
         end
         @(negedge clock);
      end
   endtask

   task automatic wait_idle(input int budget);
      for (int k = 0; k < budget; k++) begin
         if (busy === 1'b0) return;
         @(negedge clock);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      req0 = 1'b0; req1 = 1'b0; signo0 = 1'b0; signo1 = 1'b0;
      bcd0 = 16'd0; bcd1 = 16'd0;
      ifc.tx_ready = 1'b1;
      repeat (2) @(negedge clock);
      checks++;
      if ({ack0, ack1, ifc.tx_valid, busy, digit_err} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 00000", {ack0, ack1, ifc.tx_valid, busy, digit_err});
      end
      checks++;
      if (ifc.tx_data !== 8'd0) begin
         errors++;
         $display("FAIL reset_tx_data: got %0d expected 0", ifc.tx_data);
      end
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_single;
      int cnt;
      req0 = 1'b1; bcd0 = 16'h1234; signo0 = 1'b1;
      @(negedge clock);
      checks++;
      if (ack0 !== 1'b1 || ifc.tx_valid !== 1'b1) begin
         errors++;
         $display("FAIL single_latency: got ack0=%b valid=%b expected 1 1", ack0, ifc.tx_valid);
      end
      req0 = 1'b0;
      collect(4'b1111, 30);
      exp_b = '{8'd33, 8'd52, 8'd51, 8'd50, 8'd49, 8'd82};
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (got[i] !== exp_b[i]) begin
            errors++;
            $display("FAIL single_byte%0d: got %0d expected %0d", i, got[i], exp_b[i]);
         end
      end
      checks++;
      if (n_ack0 !== 1 || n_ack1 !== 0 || n_derr !== 0) begin
         errors++;
         $display("FAIL single_pulses: got ack0=%0d ack1=%0d derr=%0d expected 1 0 0", n_ack0, n_ack1, n_derr);
      end
      cnt = 0;
      for (int k = 0; k < 40; k++) begin
         if (busy !== 1'b1) break;
         cnt++;
         @(negedge clock);
      end
      checks++;
      if (cnt !== GAP) begin
         errors++;
         $display("FAIL single_gap: got %0d busy cycles expected %0d", cnt, GAP);
      end
   endtask

   task automatic test_round_robin;
      int w;
      logic [1:0] exp_ack;
      reset = 1'b1;
      req0 = 1'b1; bcd0 = 16'h1234; signo0 = 1'b1;
      req1 = 1'b1; bcd1 = 16'h0905; signo1 = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      checks++;
      if ({ack1, ack0} !== 2'b01) begin
         errors++;
         $display("FAIL rr_first_grant: got %b expected 01", {ack1, ack0});
      end
      collect(4'b1111, 30);
      exp_b = '{8'd33, 8'd52, 8'd51, 8'd50, 8'd49, 8'd82};
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (got[i] !== exp_b[i]) begin
            errors++;
            $display("FAIL rr_ch0_byte%0d: got %0d expected %0d", i, got[i], exp_b[i]);
         end
      end
      wait_valid(40, w);
      checks++;
      if (w !== GAP + 1) begin
         errors++;
         $display("FAIL rr_gap_wait: got %0d expected %0d", w, GAP + 1);
      end
      checks++;
      if ({ack1, ack0} !== 2'b10) begin
         errors++;
         $display("FAIL rr_second_grant: got %b expected 10", {ack1, ack0});
      end
      collect(4'b1111, 30);
      exp_b = '{8'd35, 8'd53, 8'd48, 8'd57, 8'd48, 8'd84};
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (got[i] !== exp_b[i]) begin
            errors++;
            $display("FAIL rr_ch1_byte%0d: got %0d expected %0d", i, got[i], exp_b[i]);
         end
      end
      for (int g = 0; g < 2; g++) begin
         exp_ack = (g == 0) ? 2'b01 : 2'b10;
         wait_valid(40, w);
         checks++;
         if ({ack1, ack0} !== exp_ack) begin
            errors++;
            $display("FAIL rr_alt_grant%0d: got %b expected %b", g, {ack1, ack0}, exp_ack);
         end
         collect(4'b1111, 30);
         checks++;
         if (n_both !== 0 || got_n !== 6) begin
            errors++;
            $display("FAIL rr_alt_frame%0d: got both=%0d bytes=%0d expected 0 6", g, n_both, got_n);
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      wait_idle(40);
   endtask

   task automatic test_backpressure;
      int w;
      @(negedge clock);
      req0 = 1'b1; bcd0 = 16'h4821; signo0 = 1'b0;
      wait_valid(5, w);
      req0 = 1'b0;
      collect(4'b1001, 40);
      exp_b = '{8'd35, 8'd49, 8'd50, 8'd56, 8'd52, 8'd82};
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (got[i] !== exp_b[i]) begin
            errors++;
            $display("FAIL bp_byte%0d: got %0d expected %0d", i, got[i], exp_b[i]);
         end
      end
      checks++;
      if (hold_viol !== 0 || n_ack0 !== 1) begin
         errors++;
         $display("FAIL bp_hold: got violations=%0d acks=%0d expected 0 1", hold_viol, n_ack0);
      end
      checks++;
      if (ifc.tx_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_extra_byte: got valid=%b expected 0", ifc.tx_valid);
      end
      wait_idle(40);
   endtask

   task automatic test_invalid_digit;
      int w;
      @(negedge clock);
      req0 = 1'b1; bcd0 = 16'h00A7; signo0 = 1'b1;
      wait_valid(5, w);
      req0 = 1'b0;
      collect(4'b1111, 30);
      exp_b = '{8'd33, 8'd55, 8'd63, 8'd48, 8'd48, 8'd82};
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (got[i] !== exp_b[i]) begin
            errors++;
            $display("FAIL baddig_byte%0d: got %0d expected %0d", i, got[i], exp_b[i]);
         end
      end
      checks++;
      if (n_derr !== 1) begin
         errors++;
         $display("FAIL baddig_pulse: got %0d pulses expected 1", n_derr);
      end
      wait_idle(40);
   endtask

   task automatic test_input_change;
      int w;
      @(negedge clock);
      req0 = 1'b1; bcd0 = 16'h2468; signo0 = 1'b1;
      wait_valid(5, w);
      bcd0 = 16'h9999; signo0 = 1'b0; req0 = 1'b0;
      collect(4'b1111, 30);
      exp_b = '{8'd33, 8'd56, 8'd54, 8'd52, 8'd50, 8'd82};
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (got[i] !== exp_b[i]) begin
            errors++;
            $display("FAIL freeze_byte%0d: got %0d expected %0d", i, got[i], exp_b[i]);
         end
      end
      wait_idle(40);
   endtask

   // Starts a channel 0 frame and lines up reset right after byte 2 is accepted.
   task automatic start_ch0_and_abort;
      int w;
      @(negedge clock);
      req0 = 1'b1; bcd0 = 16'h1234; signo0 = 1'b1;
      wait_valid(5, w);
      req0 = 1'b0;
      repeat (3) @(negedge clock);
      checks++;
      if (ifc.tx_data !== 8'd50) begin
         errors++;
         $display("FAIL abort_byte3: got %0d expected 50", ifc.tx_data);
      end
      reset = 1'b1;
   endtask

   task automatic test_reset_mid_frame;
      int w;
      start_ch0_and_abort();
      @(negedge clock);
      checks++;
      if ({ifc.tx_valid, busy, ack0, ack1, digit_err} !== 5'b0 || ifc.tx_data !== 8'd0) begin
         errors++;
         $display("FAIL abort_outputs: got flags=%b data=%0d expected 00000 0",
                  {ifc.tx_valid, busy, ack0, ack1, digit_err}, ifc.tx_data);
      end
      reset = 1'b0;
      req1 = 1'b1; bcd1 = 16'h0905; signo1 = 1'b0;
      wait_valid(5, w);
      checks++;
      if (w !== 1 || ack1 !== 1'b1) begin
         errors++;
         $display("FAIL abort_ch1_grant: got wait=%0d ack1=%b expected 1 1", w, ack1);
      end
      req1 = 1'b0;
      collect(4'b1111, 30);
      exp_b = '{8'd35, 8'd53, 8'd48, 8'd57, 8'd48, 8'd84};
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (got[i] !== exp_b[i]) begin
            errors++;
            $display("FAIL abort_ch1_byte%0d: got %0d expected %0d", i, got[i], exp_b[i]);
         end
      end
      wait_idle(40);
      start_ch0_and_abort();
      req0 = 1'b1; req1 = 1'b1;
      bcd0 = 16'h1234; signo0 = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      checks++;
      if ({ack1, ack0} !== 2'b01 || ifc.tx_data !== 8'd33) begin
         errors++;
         $display("FAIL abort_tie_grant: got acks=%b data=%0d expected 01 33", {ack1, ack0}, ifc.tx_data);
      end
      req0 = 1'b0; req1 = 1'b0;
      collect(4'b1111, 30);
      wait_idle(40);
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_invalid_digit();
      test_input_change();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
